mem_stage_ctrl: RTL and testbench
=================================

Name: mem_stage_ctrl

Overview:
- Memory stage of the ARM pipeline, directly downstream of the EXE/MEM stage register.
- Consumes that register's outputs: alu_res, val_rm, dest, wb_en, mem_r_en, mem_w_en.
- Performs loads and stores on a fixed-latency word SRAM, using a small FSM and a wait-state counter.
- Drives freeze to stall the upstream pipeline, and contains the MEM/WB register feeding write-back.

Parameters:
- ADDR_W, 6, SRAM word-address width (64 words).
- MEM_BASE, 1024, byte address mapped to SRAM word 0.
- WAIT_CYCLES, 3, extra SRAM cycles before read data is valid (0 legal).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- wb_en_in  in  1  write-back enable from EXE/MEM register.
- mem_r_en_in  in  1  load request.
- mem_w_en_in  in  1  store request.
- alu_res_in  in  32  effective byte address, or ALU result for non-memory ops.
- val_rm_in  in  32  store data.
- dest_in  in  4  destination register.
- freeze  out  1  combinational stall to PC, IF/ID, ID/EX, EXE/MEM.
- sram_en  out  1  SRAM access enable (registered).
- sram_we  out  1  SRAM write strobe (registered).
- sram_addr  out  ADDR_W  SRAM word address (registered).
- sram_wdata  out  32  SRAM write data (registered).
- sram_rdata  in  32  SRAM read data.
- wb_en  out  1  MEM/WB write-back enable.
- mem_r_en  out  1  MEM/WB load flag (selects mem_data in WB).
- alu_res  out  32  MEM/WB ALU result.
- mem_data  out  32  MEM/WB load data.
- dest  out  4  MEM/WB destination.
- mem_fault  out  1  access fault pulse (see Optional Feature).

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, counter=0.
  - sram_en, sram_we, sram_addr, sram_wdata = 0.
  - All MEM/WB outputs and mem_fault = 0.
  - Reset mid-access aborts immediately; SRAM controls drop in the same instant.
- Address translation: word_addr = ((alu_res_in - MEM_BASE) >> 2)[ADDR_W-1:0]. Subtraction is 32-bit unsigned; upper bits are discarded.
- req = mem_r_en_in | mem_w_en_in. If both are set, treat as a store; the load data is 0.
- freeze = (state==IDLE & req) | (state==ACCESS). This is combinational.
- FSM transitions:
  - IDLE, req=0: MEM/WB register loads inputs, with mem_data=0. Latency 1 cycle.
  - IDLE, req=1: go to ACCESS. Set sram_en=1, sram_we=mem_w_en_in, sram_addr=word_addr, sram_wdata=val_rm_in, counter=WAIT_CYCLES. MEM/WB loads a bubble (all 0).
  - ACCESS, counter!=0: counter-1. SRAM outputs are held stable. MEM/WB loads a bubble.
  - ACCESS, counter==0: capture sram_rdata into a data register, or 0 for a store. Clear sram_en and sram_we, go to DONE. MEM/WB loads a bubble.
  - DONE: freeze=0. MEM/WB loads the held instruction (inputs still frozen upstream) plus the captured data. Return to IDLE.
- Timing: freeze is high for exactly WAIT_CYCLES+2 cycles per memory op. sram_en is high for WAIT_CYCLES+1 cycles.
- A memory op following immediately is seen in IDLE on the cycle after DONE. There is no dead cycle beyond DONE.
- Bubbles ensure no instruction is written back twice while frozen.

Optional Feature:
- Macro: MEM_ALIGN_CHECK_EN.
- Defined:
  - In IDLE with req, if alu_res_in[1:0]!=0, alu_res_in<MEM_BASE, or alu_res_in>=MEM_BASE+4*2^ADDR_W: no SRAM access.
  - mem_fault pulses 1 for one cycle, coinciding with MEM/WB load.
  - The instruction passes in 1 cycle with wb_en forced 0; freeze stays 0.
- Undefined: no check; mem_fault is tied 0; low address bits are ignored.

Decomposition:
- Shared package holds:
  - FSM state enum (IDLE, ACCESS, DONE).
  - MEM_BASE default.
  - Data width 32.
  - Register-index width 4.
- One natural sub-module: mem_wb_reg, the MEM/WB pipeline register with load/bubble control. The FSM, counter and SRAM drive stay in mem_stage_ctrl.

Test Plan:
- Reset and pass-through:
  - rst pulsed low mid-cycle -> all outputs 0 asynchronously.
  - Then an ADD with alu_res_in=0x0000_0005, dest_in=3, wb_en_in=1 -> next cycle alu_res=5, dest=3, wb_en=1, freeze never high.
- Store:
  - mem_w_en_in=1, alu_res_in=1032, val_rm_in=0xDEAD_BEEF -> sram_addr=2, sram_we=1 for 4 cycles.
  - freeze high 5 cycles; MEM/WB wb_en=0 throughout.
- Load:
  - SRAM word 2 holds 0xDEAD_BEEF; mem_r_en_in=1, alu_res_in=1032, dest_in=7, wb_en_in=1.
  - After 5 frozen cycles: mem_data=0xDEAD_BEEF, mem_r_en=1, dest=7, wb_en=1 for exactly one cycle.
- WAIT_CYCLES=0, back-to-back loads -> freeze 2 cycles each, 1 cycle low between, both data values correct.
- Reset during ACCESS (counter=1) -> sram_en=0, state IDLE, freeze=0, no MEM/WB output.
- MEM_ALIGN_CHECK_EN, load at 1030 -> mem_fault=1 one cycle, sram_en never high, wb_en=0.

Source files
------------

// File: rtl/mem_stage_ctrl_pkg.sv
// Shared types and constants for the ARM pipeline memory stage.
package mem_stage_ctrl_pkg;

  localparam int DATA_W       = 32;
  localparam int REG_W        = 4;
  localparam int MEM_BASE_DEF = 1024;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

endpackage

// File: rtl/mem_stage_ctrl_mem_wb_reg.sv
// MEM/WB pipeline register: each cycle either loads the presented instruction
// or a bubble (all zero), so a frozen instruction is never written back twice.
module mem_wb_reg
  import mem_stage_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              bubble_i,
  input  logic              wb_en_i,
  input  logic              mem_r_en_i,
  input  logic [DATA_W-1:0] alu_res_i,
  input  logic [DATA_W-1:0] mem_data_i,
  input  logic [REG_W-1:0]  dest_i,
  output logic              wb_en_o,
  output logic              mem_r_en_o,
  output logic [DATA_W-1:0] alu_res_o,
  output logic [DATA_W-1:0] mem_data_o,
  output logic [REG_W-1:0]  dest_o
);

  logic              wb_en_q;
  logic              mem_r_en_q;
  logic [DATA_W-1:0] alu_res_q;
  logic [DATA_W-1:0] mem_data_q;
  logic [REG_W-1:0]  dest_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_en_q    <= 1'b0;
      mem_r_en_q <= 1'b0;
      alu_res_q  <= '0;
      mem_data_q <= '0;
      dest_q     <= '0;
    end else if (bubble_i) begin
      wb_en_q    <= 1'b0;
      mem_r_en_q <= 1'b0;
      alu_res_q  <= '0;
      mem_data_q <= '0;
      dest_q     <= '0;
    end else begin
      wb_en_q    <= wb_en_i;
      mem_r_en_q <= mem_r_en_i;
      alu_res_q  <= alu_res_i;
      mem_data_q <= mem_data_i;
      dest_q     <= dest_i;
    end
  end

  assign wb_en_o    = wb_en_q;
  assign mem_r_en_o = mem_r_en_q;
  assign alu_res_o  = alu_res_q;
  assign mem_data_o = mem_data_q;
  assign dest_o     = dest_q;

endmodule

// File: rtl/mem_stage_ctrl.sv
// ARM memory stage: fixed-latency SRAM access FSM, upstream freeze and MEM/WB register.
// Optional MEM_ALIGN_CHECK_EN: faulting accesses skip the SRAM and pulse mem_fault.
module mem_stage_ctrl
  import mem_stage_ctrl_pkg::*;
#(
  parameter int ADDR_W      = 6,
  parameter int MEM_BASE    = MEM_BASE_DEF,
  parameter int WAIT_CYCLES = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_en_in,
  input  logic              mem_r_en_in,
  input  logic              mem_w_en_in,
  input  logic [DATA_W-1:0] alu_res_in,
  input  logic [DATA_W-1:0] val_rm_in,
  input  logic [REG_W-1:0]  dest_in,
  output logic              freeze,
  output logic              sram_en,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic              wb_en,
  output logic              mem_r_en,
  output logic [DATA_W-1:0] alu_res,
  output logic [DATA_W-1:0] mem_data,
  output logic [REG_W-1:0]  dest,
  output logic              mem_fault
);

  localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              sram_en_q, sram_en_d;
  logic              sram_we_q, sram_we_d;
  logic [ADDR_W-1:0] sram_addr_q, sram_addr_d;
  logic [DATA_W-1:0] sram_wdata_q, sram_wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic              req;
  logic              access_fault;
  logic [ADDR_W-1:0] word_addr;
  logic              wb_bubble;
  logic [DATA_W-1:0] wb_data;
  logic              wb_en_fwd;

  assign req       = mem_r_en_in | mem_w_en_in;
  assign word_addr = ADDR_W'((alu_res_in - 32'(MEM_BASE)) >> 2);

`ifdef MEM_ALIGN_CHECK_EN
  localparam logic [DATA_W-1:0] MEM_LIMIT = 32'(MEM_BASE) + 32'(4 * (2 ** ADDR_W));

  logic fault_q;

  assign access_fault = req & ((alu_res_in[1:0] != 2'b00) |
                               (alu_res_in < 32'(MEM_BASE)) |
                               (alu_res_in >= MEM_LIMIT));

  // The fault pulse lines up with the MEM/WB load of the faulting instruction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) fault_q <= 1'b0;
    else      fault_q <= (state_q == IDLE) & access_fault;
  end

  assign mem_fault = fault_q;
`else
  assign access_fault = 1'b0;
  assign mem_fault    = 1'b0;
`endif

  assign wb_en_fwd = wb_en_in & ~access_fault;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      sram_en_q    <= 1'b0;
      sram_we_q    <= 1'b0;
      sram_addr_q  <= '0;
      sram_wdata_q <= '0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sram_en_q    <= sram_en_d;
      sram_we_q    <= sram_we_d;
      sram_addr_q  <= sram_addr_d;
      sram_wdata_q <= sram_wdata_d;
      rdata_q      <= rdata_d;
    end
  end

  // Loads and stores take IDLE -> ACCESS (WAIT_CYCLES+1 cycles) -> DONE; only
  // DONE releases the held instruction into MEM/WB, everything else is a bubble.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    sram_en_d    = sram_en_q;
    sram_we_d    = sram_we_q;
    sram_addr_d  = sram_addr_q;
    sram_wdata_d = sram_wdata_q;
    rdata_d      = rdata_q;
    freeze       = 1'b0;
    wb_bubble    = 1'b1;
    wb_data      = '0;
    case (state_q)
      IDLE: begin
        if (req && !access_fault) begin
          freeze       = 1'b1;
          state_d      = ACCESS;
          cnt_d        = CNT_W'(WAIT_CYCLES);
          sram_en_d    = 1'b1;
          sram_we_d    = mem_w_en_in;
          sram_addr_d  = word_addr;
          sram_wdata_d = val_rm_in;
        end else begin
          wb_bubble = 1'b0;
        end
      end
      ACCESS: begin
        freeze = 1'b1;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          rdata_d   = sram_we_q ? '0 : sram_rdata;
          sram_en_d = 1'b0;
          sram_we_d = 1'b0;
          state_d   = DONE;
        end
      end
      DONE: begin
        wb_bubble = 1'b0;
        wb_data   = rdata_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign sram_en    = sram_en_q;
  assign sram_we    = sram_we_q;
  assign sram_addr  = sram_addr_q;
  assign sram_wdata = sram_wdata_q;

  mem_wb_reg u_mem_wb_reg (
    .clk        (clk),
    .rst        (rst),
    .bubble_i   (wb_bubble),
    .wb_en_i    (wb_en_fwd),
    .mem_r_en_i (mem_r_en_in),
    .alu_res_i  (alu_res_in),
    .mem_data_i (wb_data),
    .dest_i     (dest_in),
    .wb_en_o    (wb_en),
    .mem_r_en_o (mem_r_en),
    .alu_res_o  (alu_res),
    .mem_data_o (mem_data),
    .dest_o     (dest)
  );

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Scoreboard bench for mem_stage_ctrl: dutA uses WAIT_CYCLES=3, dutB uses WAIT_CYCLES=0.
// Expectations for MEM_ALIGN_CHECK_EN builds are selected with the same macro.
module tb_mem_stage_ctrl;

  typedef struct packed {
    logic        wbEn;
    logic        memREn;
    logic [31:0] aluRes;
    logic [31:0] memData;
    logic [3:0]  dest;
    logic        fault;
  } wbTxn_t;

  logic clk;
  logic rst;

  logic        aWbEn, aRd, aWr;
  logic [31:0] aAlu, aRm;
  logic [3:0]  aDest;
  logic        aFreeze, aEn, aWe;
  logic [5:0]  aAddr;
  logic [31:0] aWdata, aRdata;
  logic        aWbEnO, aMemREnO, aFaultO;
  logic [31:0] aAluO, aDataO;
  logic [3:0]  aDestO;

  logic        bWbEn, bRd, bWr;
  logic [31:0] bAlu, bRm;
  logic [3:0]  bDest;
  logic        bFreeze, bEn, bWe;
  logic [5:0]  bAddr;
  logic [31:0] bWdata, bRdata;
  logic        bWbEnO, bMemREnO, bFaultO;
  logic [31:0] bAluO, bDataO;
  logic [3:0]  bDestO;

  logic [31:0] memA [64];
  logic [31:0] memB [64];

  wbTxn_t expQA[$];
  wbTxn_t expQB[$];
  wbTxn_t gotA, wantA, gotB, wantB;

  int total = 0;
  int bad   = 0;

  mem_stage_ctrl #(.ADDR_W(6), .MEM_BASE(1024), .WAIT_CYCLES(3)) dutA (
    .clk(clk), .rst(rst),
    .wb_en_in(aWbEn), .mem_r_en_in(aRd), .mem_w_en_in(aWr),
    .alu_res_in(aAlu), .val_rm_in(aRm), .dest_in(aDest),
    .freeze(aFreeze), .sram_en(aEn), .sram_we(aWe), .sram_addr(aAddr),
    .sram_wdata(aWdata), .sram_rdata(aRdata),
    .wb_en(aWbEnO), .mem_r_en(aMemREnO), .alu_res(aAluO), .mem_data(aDataO),
    .dest(aDestO), .mem_fault(aFaultO)
  );

  mem_stage_ctrl #(.ADDR_W(6), .MEM_BASE(1024), .WAIT_CYCLES(0)) dutB (
    .clk(clk), .rst(rst),
    .wb_en_in(bWbEn), .mem_r_en_in(bRd), .mem_w_en_in(bWr),
    .alu_res_in(bAlu), .val_rm_in(bRm), .dest_in(bDest),
    .freeze(bFreeze), .sram_en(bEn), .sram_we(bWe), .sram_addr(bAddr),
    .sram_wdata(bWdata), .sram_rdata(bRdata),
    .wb_en(bWbEnO), .mem_r_en(bMemREnO), .alu_res(bAluO), .mem_data(bDataO),
    .dest(bDestO), .mem_fault(bFaultO)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // SRAM models: write on the clock edge, read combinationally from the held address.
  initial begin
    for (int i = 0; i < 64; i++) begin
      memA[i] = 32'h0;
      memB[i] = 32'h0;
    end
  end

  always @(posedge clk) begin
    if (aEn && aWe) memA[aAddr] <= aWdata;
    if (bEn && bWe) memB[bAddr] <= bWdata;
  end

  assign aRdata = aEn ? memA[aAddr] : 32'h0;
  assign bRdata = bEn ? memB[bAddr] : 32'h0;

  // Any non-bubble MEM/WB content must match the next expected transaction.
  always @(negedge clk) begin
    if (rst && (aWbEnO || aMemREnO || aFaultO || aAluO != 32'h0 || aDestO != 4'h0)) begin
      gotA = {aWbEnO, aMemREnO, aAluO, aDataO, aDestO, aFaultO};
      total++;
      if (expQA.size() == 0) begin
        bad++;
        $display("[TB] FAIL wbA unexpected: got=%h", gotA);
      end else begin
        wantA = expQA.pop_front();
        if (gotA !== wantA) begin
          bad++;
          $display("[TB] FAIL wbA: got=%h exp=%h", gotA, wantA);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst && (bWbEnO || bMemREnO || bFaultO || bAluO != 32'h0 || bDestO != 4'h0)) begin
      gotB = {bWbEnO, bMemREnO, bAluO, bDataO, bDestO, bFaultO};
      total++;
      if (expQB.size() == 0) begin
        bad++;
        $display("[TB] FAIL wbB unexpected: got=%h", gotB);
      end else begin
        wantB = expQB.pop_front();
        if (gotB !== wantB) begin
          bad++;
          $display("[TB] FAIL wbB: got=%h exp=%h", gotB, wantB);
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%h exp=%h", name, act, exp);
    end
  endtask

  // Drives one instruction (called #1 after a rising edge), holds it while frozen,
  // measures freeze/SRAM activity, and queues the expected MEM/WB result.
  task automatic applyStimulus(input string name, input bit sel,
                               input logic wr, input logic rd, input logic wen,
                               input logic [31:0] alu, input logic [31:0] rm,
                               input logic [3:0] d, input logic [31:0] expData,
                               input logic expFault, input int expFrz,
                               input int expEn, input int expWe,
                               input logic [5:0] expAddr);
    wbTxn_t txn;
    int frz = 0;
    int en = 0;
    int we = 0;
    bit done = 0;
    logic [5:0] addr = 6'h0;
    logic [31:0] wd = 32'h0;
    txn = {(expFault ? 1'b0 : wen), rd, alu, expData, d, expFault};
    if (sel) begin
      bWr = wr; bRd = rd; bWbEn = wen; bAlu = alu; bRm = rm; bDest = d;
      expQB.push_back(txn);
    end else begin
      aWr = wr; aRd = rd; aWbEn = wen; aAlu = alu; aRm = rm; aDest = d;
      expQA.push_back(txn);
    end
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (sel ? bEn : aEn) begin
        en++;
        addr = sel ? bAddr : aAddr;
        wd   = sel ? bWdata : aWdata;
      end
      if (sel ? bWe : aWe) we++;
      if (!(sel ? bFreeze : aFreeze)) begin
        done = 1;
        break;
      end
      frz++;
    end
    if (!done) begin
      total++;
      bad++;
      $display("[TB] FAIL %s freeze timeout: got=stuck exp=release", name);
    end
    @(posedge clk);
    #1;
    if (sel) begin
      bWr = 0; bRd = 0; bWbEn = 0; bAlu = 0; bRm = 0; bDest = 0;
    end else begin
      aWr = 0; aRd = 0; aWbEn = 0; aAlu = 0; aRm = 0; aDest = 0;
    end
    checkOutput({name, " freeze cycles"}, frz, expFrz);
    checkOutput({name, " sram_en cycles"}, en, expEn);
    checkOutput({name, " sram_we cycles"}, we, expWe);
    if (expEn != 0) checkOutput({name, " sram_addr"}, {26'h0, addr}, {26'h0, expAddr});
    if (expWe != 0) checkOutput({name, " sram_wdata"}, wd, rm);
  endtask

  initial begin
    rst = 1'b1;
    aWr = 0; aRd = 0; aWbEn = 0; aAlu = 0; aRm = 0; aDest = 0;
    bWr = 0; bRd = 0; bWbEn = 0; bAlu = 0; bRm = 0; bDest = 0;

    #3 rst = 1'b0;
    #1;
    checkOutput("reset sram_en", {31'h0, aEn}, 32'h0);
    checkOutput("reset sram_we", {31'h0, aWe}, 32'h0);
    checkOutput("reset sram_addr", {26'h0, aAddr}, 32'h0);
    checkOutput("reset sram_wdata", aWdata, 32'h0);
    checkOutput("reset wb", {aWbEnO, aMemREnO, aDestO, aFaultO, aFreeze}, 32'h0);
    checkOutput("reset alu_res", aAluO, 32'h0);
    checkOutput("reset mem_data", aDataO, 32'h0);
    checkOutput("reset B sram/wb", {bEn, bWe, bWbEnO, bMemREnO, bDestO, bFaultO, bFreeze}, 32'h0);
    #8 rst = 1'b1;
    @(posedge clk);
    #1;

    applyStimulus("add", 0, 0, 0, 1, 32'h5, 32'h0, 4'd3, 32'h0, 0, 0, 0, 0, 6'd0);

    // Asynchronous clear while the ADD result is still presented.
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checkOutput("async rst alu_res", aAluO, 32'h0);
    checkOutput("async rst wb_en/dest", {27'h0, aWbEnO, aDestO}, 32'h0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    applyStimulus("store", 0, 1, 0, 0, 32'd1032, 32'hDEAD_BEEF, 4'd0, 32'h0, 0, 5, 4, 4, 6'd2);
    applyStimulus("load", 0, 0, 1, 1, 32'd1032, 32'h0, 4'd7, 32'hDEAD_BEEF, 0, 5, 4, 0, 6'd2);
    applyStimulus("rd+wr", 0, 1, 1, 1, 32'd1040, 32'h0BAD_F00D, 4'd9, 32'h0, 0, 5, 4, 4, 6'd4);
    applyStimulus("load w4", 0, 0, 1, 1, 32'd1040, 32'h0, 4'd5, 32'h0BAD_F00D, 0, 5, 4, 0, 6'd4);
`ifdef MEM_ALIGN_CHECK_EN
    applyStimulus("load high", 0, 0, 1, 1, 32'd1288, 32'h0, 4'd8, 32'h0, 1, 0, 0, 0, 6'd0);
    applyStimulus("load 1030", 0, 0, 1, 1, 32'd1030, 32'h0, 4'd2, 32'h0, 1, 0, 0, 0, 6'd0);
`else
    applyStimulus("load wrap", 0, 0, 1, 1, 32'd1288, 32'h0, 4'd8, 32'hDEAD_BEEF, 0, 5, 4, 0, 6'd2);
    applyStimulus("load 1030", 0, 0, 1, 1, 32'd1030, 32'h0, 4'd2, 32'h0, 0, 5, 4, 0, 6'd1);
`endif

    // Reset while counter==1: the access is abandoned with no write-back.
    aRd = 1; aAlu = 32'd1032; aDest = 4'd7; aWbEn = 1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("abort pre sram_en", {31'h0, aEn}, 32'h1);
    #1;
    rst = 1'b0;
    aRd = 0; aAlu = 0; aDest = 0; aWbEn = 0;
    #1;
    checkOutput("abort sram_en/we", {30'h0, aEn, aWe}, 32'h0);
    checkOutput("abort freeze", {31'h0, aFreeze}, 32'h0);
    checkOutput("abort wb_en/data", aDataO | {31'h0, aWbEnO}, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus("add after abort", 0, 0, 0, 1, 32'h77, 32'h0, 4'd2, 32'h0, 0, 0, 0, 0, 6'd0);

    applyStimulus("B store w1", 1, 1, 0, 0, 32'd1028, 32'h1234_5678, 4'd0, 32'h0, 0, 2, 1, 1, 6'd1);
    applyStimulus("B store w3", 1, 1, 0, 0, 32'd1036, 32'hCAFE_F00D, 4'd0, 32'h0, 0, 2, 1, 1, 6'd3);
    applyStimulus("B load w1", 1, 0, 1, 1, 32'd1028, 32'h0, 4'd4, 32'h1234_5678, 0, 2, 1, 0, 6'd1);
    applyStimulus("B load w3", 1, 0, 1, 1, 32'd1036, 32'h0, 4'd6, 32'hCAFE_F00D, 0, 2, 1, 0, 6'd3);
    applyStimulus("B add", 1, 0, 0, 1, 32'h42, 32'h0, 4'd1, 32'h0, 0, 0, 0, 0, 6'd0);

    repeat (4) @(posedge clk);
    #1;
    checkOutput("scoreboard A drained", expQA.size(), 32'h0);
    checkOutput("scoreboard B drained", expQB.size(), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
